// File: rtl/axis_dac_shaper_pkg.sv
// axis_dac_shaper_pkg
// Shared definitions for the AXI-Stream DAC TX shaper:
//   - tx_state_e    : FSM state encoding, also exported on sts_state
//   - ENV_FULL      : envelope full-scale value for the default envelope width
//   - lane_get      : extract one 16-bit lane from a two-lane stream word
//   - sext_lane     : sign-extend a narrow sample to the full 16-bit lane
package axis_dac_shaper_pkg;

    localparam int unsigned LANE_WIDTH    = 16;
    localparam int unsigned DEF_ENV_WIDTH = 16;
    localparam int unsigned ENV_FULL      = 1 << DEF_ENV_WIDTH;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRampUp   = 2'd1,
        StOn       = 2'd2,
        StRampDown = 2'd3
    } tx_state_e;

    function automatic logic [LANE_WIDTH-1:0] lane_get(input logic [2*LANE_WIDTH-1:0] data,
                                                       input int unsigned idx);
        return data[idx*LANE_WIDTH +: LANE_WIDTH];
    endfunction

    // Replicate bit w-1 into every bit above it.
    function automatic logic [LANE_WIDTH-1:0] sext_lane(input logic [LANE_WIDTH-1:0] v,
                                                        input int unsigned w);
        logic [LANE_WIDTH-1:0] r;
        r = v;
        for (int i = 0; i < LANE_WIDTH; i++) begin
            if (i >= int'(w)) r[i] = v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_dac_shaper_mul.sv
// axis_dac_shaper_mul
// One lane of the shaper's second pipeline stage: multiplies a signed sample by the unsigned
// envelope, shifts right arithmetically by ENV_WIDTH (floor), and registers the result
// sign-extended to a 16-bit lane.
// Ports:
//   aclk, areset : clock, synchronous active-high reset (clears the output lane)
//   en           : stage advance; the output register loads only when set
//   sample       : signed SAMPLE_WIDTH-bit sample from stage 1
//   env          : envelope, 0..2^ENV_WIDTH
//   lane         : registered shaped lane
module axis_dac_shaper_mul
    import axis_dac_shaper_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 14,
    parameter int unsigned ENV_WIDTH    = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [ENV_WIDTH:0]      env,
    output logic [LANE_WIDTH-1:0]   lane
);

    localparam int unsigned PROD_WIDTH = SAMPLE_WIDTH + ENV_WIDTH + 1;

    logic signed [PROD_WIDTH-1:0]   prod;
    logic signed [SAMPLE_WIDTH-1:0] scaled;
    logic        [LANE_WIDTH-1:0]   lane_d;

    // env is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod   = PROD_WIDTH'($signed(sample)) * PROD_WIDTH'($signed({1'b0, env}));
    // |result| <= |sample| since env <= full scale, so truncation loses nothing.
    assign scaled = SAMPLE_WIDTH'(prod >>> ENV_WIDTH);
    assign lane_d = sext_lane({{(LANE_WIDTH - SAMPLE_WIDTH){1'b0}}, scaled}, SAMPLE_WIDTH);

    always_ff @(posedge aclk) begin
        if (areset) begin
            lane <= '0;
        end else if (en) begin
            lane <= lane_d;
        end
    end

endmodule

// File: rtl/axis_dac_tx_shaper.sv
// axis_dac_tx_shaper
// Gates a two-lane AXI-Stream DAC sample stream with a TX key and applies a linear amplitude
// envelope on key-on / key-off. Two register stages: S1 holds sample + env, S2 the product.
// Optional feature macro: AXIS_DAC_SHAPER_CHB_EN -- when defined lane B is shaped by a second
// multiplier; otherwise lane B output is forced to zero.
// Ports:
//   aclk, areset        : clock, synchronous active-high reset
//   key                 : TX enable, level sensitive
//   cfg_step            : envelope step per accepted sample (0 behaves as 1)
//   s_axis_*            : input stream (lane A [15:0], lane B [31:16])
//   m_axis_*            : shaped output stream
//   sts_state           : FSM state code (0 idle, 1 ramp up, 2 on, 3 ramp down)
module axis_dac_tx_shaper
    import axis_dac_shaper_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned SAMPLE_WIDTH     = 14,
    parameter int unsigned ENV_WIDTH        = DEF_ENV_WIDTH
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        key,
    input  logic [ENV_WIDTH-1:0]        cfg_step,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic [1:0]                  sts_state
);

    localparam logic [ENV_WIDTH:0] FULL = {1'b1, {ENV_WIDTH{1'b0}}};

    tx_state_e              state;
    logic [ENV_WIDTH:0]     env;
    logic [ENV_WIDTH:0]     env_next;
    logic [ENV_WIDTH+1:0]   env_up;
    logic [ENV_WIDTH-1:0]   step;

    logic                   s1_valid;
    logic                   s2_valid;
    logic                   s1_adv;
    logic                   s2_adv;
    logic                   s_hs;
    logic [SAMPLE_WIDTH-1:0] s1_sample_a;
    logic [ENV_WIDTH:0]     s1_env;

    logic [LANE_WIDTH-1:0]  lane_a_in;
    logic [LANE_WIDTH-1:0]  lane_b_in;
    logic [LANE_WIDTH-1:0]  lane_a_out;
    logic [LANE_WIDTH-1:0]  lane_b_out;

    assign lane_a_in = lane_get(s_axis_tdata, 0);
    assign lane_b_in = lane_get(s_axis_tdata, 1);

    // ---------------------------------------------------------------- handshake / backpressure
    assign s2_adv        = !s2_valid || m_axis_tready;
    assign s1_adv        = !s1_valid || s2_adv;
    // IDLE swallows input so upstream never stalls while the transmitter is keyed off.
    assign s_axis_tready = (state == StIdle) ? 1'b1 : s1_adv;
    assign s_hs          = s_axis_tvalid && s_axis_tready;

    // ---------------------------------------------------------------- envelope arithmetic
    assign step   = (cfg_step == '0) ? ENV_WIDTH'(1) : cfg_step;
    assign env_up = {1'b0, env} + {2'b00, step};

    always_comb begin
        env_next = env;
        if (s_hs) begin
            if (state == StRampUp) begin
                env_next = (env_up >= {1'b0, FULL}) ? FULL : env_up[ENV_WIDTH:0];
            end else if (state == StRampDown) begin
                env_next = (env <= {1'b0, step}) ? '0 : env - {1'b0, step};
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    // env follows its ramp on every handshake; a key change wins over reaching a limit.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= StIdle;
            env   <= '0;
        end else begin
            env <= env_next;
            unique case (state)
                StIdle: begin
                    env <= '0;
                    if (key) state <= StRampUp;
                end
                StRampUp: begin
                    if (!key) state <= StRampDown;
                    else if (env_next == FULL) state <= StOn;
                end
                StOn: begin
                    env <= FULL;
                    if (!key) state <= StRampDown;
                end
                StRampDown: begin
                    if (key) state <= StRampUp;
                    else if (env_next == '0) state <= StIdle;
                end
            endcase
        end
    end

    assign sts_state = state;

    // ---------------------------------------------------------------- stage 1
    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s1_sample_a <= '0;
            s1_env      <= '0;
        end else begin
            if (s1_adv) begin
                // Samples accepted in IDLE are dropped here.
                s1_valid    <= s_hs && (state != StIdle);
                s1_sample_a <= SAMPLE_WIDTH'(lane_a_in);
                s1_env      <= env;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    axis_dac_shaper_mul #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .ENV_WIDTH    (ENV_WIDTH)
    ) u_mul_a (
        .aclk   (aclk),
        .areset (areset),
        .en     (s2_adv),
        .sample (s1_sample_a),
        .env    (s1_env),
        .lane   (lane_a_out)
    );

`ifdef AXIS_DAC_SHAPER_CHB_EN
    logic [SAMPLE_WIDTH-1:0] s1_sample_b;
    logic                    unused_lane_hi;

    assign unused_lane_hi = ^{lane_a_in[LANE_WIDTH-1:SAMPLE_WIDTH],
                              lane_b_in[LANE_WIDTH-1:SAMPLE_WIDTH]};

    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_sample_b <= '0;
        end else if (s1_adv) begin
            s1_sample_b <= SAMPLE_WIDTH'(lane_b_in);
        end
    end

    axis_dac_shaper_mul #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .ENV_WIDTH    (ENV_WIDTH)
    ) u_mul_b (
        .aclk   (aclk),
        .areset (areset),
        .en     (s2_adv),
        .sample (s1_sample_b),
        .env    (s1_env),
        .lane   (lane_b_out)
    );
`else
    logic unused_lane_hi;

    assign unused_lane_hi = ^{lane_a_in[LANE_WIDTH-1:SAMPLE_WIDTH], lane_b_in};
    assign lane_b_out     = '0;
`endif

    assign m_axis_tvalid = s2_valid;
    assign m_axis_tdata  = {lane_b_out, lane_a_out};

endmodule

// File: tb/tb_axis_dac_tx_shaper.sv
// tb_axis_dac_tx_shaper
// Scoreboard bench: a behavioural model tracks key/envelope state from the accepted handshakes
// and queues the expected shaped words; an independent monitor pops them as the DUT emits.
module tb_axis_dac_tx_shaper;
    import axis_dac_shaper_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic        key;
    logic [15:0] cfg_step;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic [1:0]  sts_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mstate   = 0;  // 0 idle, 1 ramp up, 2 on, 3 ramp down
    int          menv     = 0;
    logic [31:0] exp_q[$];

    axis_dac_tx_shaper dut (
        .aclk          (aclk),
        .areset        (areset),
        .key           (key),
        .cfg_step      (cfg_step),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .sts_state     (sts_state)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // (sample * env) / 2^16 rounded toward -inf, as a 16-bit lane.
    function automatic logic [15:0] shape(input logic [15:0] lane, input int env);
        logic signed [13:0] s14;
        longint             p;
        s14 = lane[13:0];
        p   = longint'(s14) * longint'(env);
        p   = p >>> 16;
        return 16'(p);
    endfunction

    function automatic logic [15:0] rnd_lane();
        int v;
        v = int'($urandom_range(16383, 0)) - 8192;
        return 16'(v);
    endfunction

    // ------------------------------------------------------------------ reference model
    initial begin
        bit          hs;
        int          stp;
        logic [15:0] exp_b;
        forever begin
            @(negedge aclk);
            if (areset) begin
                mstate = 0;
                menv   = 0;
                exp_q.delete();
            end else begin
                check("sts_state", {30'd0, sts_state}, 32'(mstate));
                if (mstate == 0) check("tready_idle", {31'd0, s_axis_tready}, 32'd1);
                hs  = s_axis_tvalid && s_axis_tready;
                stp = (cfg_step == 16'd0) ? 1 : int'(cfg_step);
                if (hs && mstate != 0) begin
`ifdef AXIS_DAC_SHAPER_CHB_EN
                    exp_b = shape(s_axis_tdata[31:16], menv);
`else
                    exp_b = 16'd0;
`endif
                    exp_q.push_back({exp_b, shape(s_axis_tdata[15:0], menv)});
                end
                if (mstate == 0) begin
                    if (key) mstate = 1;
                end else if (mstate == 1) begin
                    if (hs) menv = (menv + stp > 65536) ? 65536 : menv + stp;
                    if (!key) mstate = 3;
                    else if (menv == 65536) mstate = 2;
                end else if (mstate == 2) begin
                    if (!key) mstate = 3;
                end else begin
                    if (hs) menv = (menv - stp < 0) ? 0 : menv - stp;
                    if (key) mstate = 1;
                    else if (menv == 0) mstate = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------ output monitor
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge aclk);
            if (!areset && m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", m_axis_tdata, 32'hxxxx_xxxx);
                end else begin
                    exp = exp_q.pop_front();
                    check("m_axis_tdata", m_axis_tdata, exp);
                end
            end
        end
    end

    // ------------------------------------------------------------------ stimulus
    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [15:0] laneb_exp;
        int          budget;
`ifdef AXIS_DAC_SHAPER_CHB_EN
        laneb_exp = 16'd1000;
`else
        laneb_exp = 16'd0;
`endif
        areset        = 1'b1;
        key           = 1'b0;
        cfg_step      = 16'd16384;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        m_axis_tready = 1'b1;
        cycles(3);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_tready", {31'd0, s_axis_tready}, 32'd1);
        check("rst_state", {30'd0, sts_state}, 32'd0);
        areset = 1'b0;

        // Ramp up to full scale with a constant positive sample.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {16'd0, 16'd4096};
        key           = 1'b1;
        cycles(12);
        check("ramp_up_on", {30'd0, sts_state}, 32'd2);

        // Negative sample, ramp down to idle and drain.
        s_axis_tdata = {16'd0, 16'hF000};
        key          = 1'b0;
        cycles(10);
        check("ramp_dn_idle", {30'd0, sts_state}, 32'd0);
        check("ramp_dn_drained", {31'd0, m_axis_tvalid}, 32'd0);

        // Key drop part way through the ramp.
        s_axis_tdata = {16'd0, 16'd4096};
        key          = 1'b1;
        cycles(3);
        key = 1'b0;
        cycles(8);
        check("drop_idle", {30'd0, sts_state}, 32'd0);

        // Output stall during ramp up.
        cfg_step = 16'd4096;
        key      = 1'b1;
        cycles(4);
        m_axis_tready = 1'b0;
        cycles(2);
        check("stall_tready", {31'd0, s_axis_tready}, 32'd0);
        cycles(3);
        m_axis_tready = 1'b1;
        cycles(20);
        key = 1'b0;
        cycles(40);
        check("stall_idle", {30'd0, sts_state}, 32'd0);

        // Reset pulse while ON.
        cfg_step = 16'd16384;
        key      = 1'b1;
        cycles(8);
        check("pre_rst_on", {30'd0, sts_state}, 32'd2);
        areset = 1'b1;
        cycles(1);
        check("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("midrst_state", {30'd0, sts_state}, 32'd0);
        key    = 1'b0;
        areset = 1'b0;
        cycles(2);

        // Zero step advances by one per sample.
        cfg_step     = 16'd0;
        s_axis_tdata = {16'd0, 16'hE000};
        key          = 1'b1;
        cycles(30);
        check("zero_step_ramping", {30'd0, sts_state}, 32'd1);
        key = 1'b0;
        cycles(50);
        check("zero_step_idle", {30'd0, sts_state}, 32'd0);

        // Lane B at full scale.
        cfg_step     = 16'd16384;
        s_axis_tdata = {16'd1000, rnd_lane()};
        key          = 1'b1;
        cycles(10);
        check("laneb_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("laneb_on", {16'd0, m_axis_tdata[31:16]}, {16'd0, laneb_exp});
        key = 1'b0;
        cycles(10);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            s_axis_tvalid = ($urandom_range(3, 0) != 0);
            m_axis_tready = ($urandom_range(4, 0) != 0);
            s_axis_tdata  = {rnd_lane(), rnd_lane()};
            if ($urandom_range(39, 0) == 0) key = ~key;
            if ($urandom_range(15, 0) == 0) begin
                case ($urandom_range(4, 0))
                    0:       cfg_step = 16'd0;
                    1:       cfg_step = 16'hFFFF;
                    2:       cfg_step = 16'd16384;
                    3:       cfg_step = 16'($urandom_range(64, 1));
                    default: cfg_step = 16'($urandom);
                endcase
            end
            cycles(1);
        end

        // Drain to idle with a bounded wait.
        key           = 1'b0;
        cfg_step      = 16'd16384;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        budget        = 200;
        while ((mstate != 0 || exp_q.size() != 0 || m_axis_tvalid) && budget > 0) begin
            cycles(1);
            budget--;
        end
        check("drain_timeout", 32'(budget > 0), 32'd1);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
